// File: rtl/adj_button_ctrl.sv
// Pushbutton front end for the pixel adjust blocks: sync, debounce, one pulse per press
// with hold-to-repeat, clamped at level 0x0/0xF. Define ADJ_AUTOREPEAT_EN to build the repeat path.
module adj_button_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000,
  parameter int CNT_W           = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up_n,
  input  logic       btn_dn_n,
  input  logic [3:0] level_in,
  output logic       inc,
  output logic       dec,
  output logic       held
);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_RATE < 2 || REPEAT_DELAY <= REPEAT_RATE ||
      longint'(REPEAT_DELAY) > (64'd1 << CNT_W)) begin : g_bad_cfg
    $error("adj_button_ctrl: invalid timing parameters");
  end

`ifdef ADJ_AUTOREPEAT_EN
  typedef enum logic [2:0] {IDLE, FIRST, WAIT_DLY, REPEAT, LOCK} state_t;
`else
  typedef enum logic [2:0] {IDLE, FIRST, HOLD, LOCK} state_t;
`endif

  logic [1:0]            up_sync_q, dn_sync_q;
  logic [1:0]            key_s;                 // [0]=up, [1]=dn, active-high
  logic [1:0]            deb_q;
  logic [1:0][CNT_W-1:0] db_cnt_q;
  state_t                state_q, state_d;
  logic                  dir_up_q, dir_up_d;
  logic                  inc_q, dec_q, held_q;
  logic                  pulse, own_key, other_key;
`ifdef ADJ_AUTOREPEAT_EN
  logic [CNT_W-1:0]      rpt_cnt_q, rpt_cnt_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      up_sync_q <= 2'b11;
      dn_sync_q <= 2'b11;
    end else begin
      up_sync_q <= {up_sync_q[0], btn_up_n};
      dn_sync_q <= {dn_sync_q[0], btn_dn_n};
    end
  end

  assign key_s = {~dn_sync_q[1], ~up_sync_q[1]};

  // A key change is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_q    <= '0;
      db_cnt_q <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (key_s[k] == deb_q[k]) begin
          db_cnt_q[k] <= '0;
        end else if (db_cnt_q[k] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          deb_q[k]    <= key_s[k];
          db_cnt_q[k] <= '0;
        end else begin
          db_cnt_q[k] <= db_cnt_q[k] + CNT_W'(1);
        end
      end
    end
  end

  assign own_key   = dir_up_q ? deb_q[0] : deb_q[1];
  assign other_key = dir_up_q ? deb_q[1] : deb_q[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      dir_up_q <= 1'b0;
      inc_q    <= 1'b0;
      dec_q    <= 1'b0;
      held_q   <= 1'b0;
`ifdef ADJ_AUTOREPEAT_EN
      rpt_cnt_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      dir_up_q <= dir_up_d;
      inc_q    <= pulse &  dir_up_q & (level_in != 4'hF);
      dec_q    <= pulse & ~dir_up_q & (level_in != 4'h0);
      held_q   <= (state_q != IDLE) && (state_q != LOCK);
`ifdef ADJ_AUTOREPEAT_EN
      rpt_cnt_q <= rpt_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    dir_up_d = dir_up_q;
    pulse    = 1'b0;
`ifdef ADJ_AUTOREPEAT_EN
    rpt_cnt_d = rpt_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (deb_q[0] && deb_q[1]) begin
          state_d = LOCK;
        end else if (deb_q[0] ^ deb_q[1]) begin
          state_d  = FIRST;
          dir_up_d = deb_q[0];
        end
      end
      LOCK: begin
        if (!deb_q[0] && !deb_q[1]) state_d = IDLE;
      end
      default: begin
        // Abort paths win over any scheduled pulse in the same cycle.
        if (other_key) begin
          state_d = LOCK;
        end else if (!own_key) begin
          state_d = IDLE;
        end else begin
          case (state_q)
            FIRST: begin
              pulse = 1'b1;
`ifdef ADJ_AUTOREPEAT_EN
              rpt_cnt_d = '0;
              state_d   = WAIT_DLY;
`else
              state_d   = HOLD;
`endif
            end
`ifdef ADJ_AUTOREPEAT_EN
            WAIT_DLY: begin
              if (rpt_cnt_q == CNT_W'(REPEAT_DELAY - 1)) begin
                pulse     = 1'b1;
                rpt_cnt_d = '0;
                state_d   = REPEAT;
              end else begin
                rpt_cnt_d = rpt_cnt_q + CNT_W'(1);
              end
            end
            REPEAT: begin
              if (rpt_cnt_q == CNT_W'(REPEAT_RATE - 1)) begin
                pulse     = 1'b1;
                rpt_cnt_d = '0;
              end else begin
                rpt_cnt_d = rpt_cnt_q + CNT_W'(1);
              end
            end
`endif
            default: ;
          endcase
        end
      end
    endcase
  end

  assign inc  = inc_q;
  assign dec  = dec_q;
  assign held = held_q;

endmodule

// File: tb/tb_adj_button_ctrl.sv
// Bench for adj_button_ctrl: directed scenarios plus random key/level traffic, checked every
// cycle against a slot-arithmetic reference model.
module tb_adj_button_ctrl;

  localparam int DB   = 4;
  localparam int DLY  = 20;
  localparam int RATE = 8;
`ifdef ADJ_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_up_n, btn_dn_n;
  logic [3:0] level_in;
  logic       inc, dec, held;

  adj_button_ctrl #(
    .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(DLY), .REPEAT_RATE(RATE), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .btn_up_n(btn_up_n), .btn_dn_n(btn_dn_n),
    .level_in(level_in), .inc(inc), .dec(dec), .held(held)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    failures = 0;
  int    n_inc, n_dec;
  string phase = "reset";

  // Reference model: keys are "accepted" once the last DB synchronized samples all
  // disagree with the accepted value; pulses fall on fixed slots counted from activation.
  bit          ms1u, ms2u, ms1d, ms2d, mdu, mdd;
  bit [DB-1:0] hu, hd;
  int          mmode;      // 0 idle, 1 active, 2 locked
  int          mstart, medge;
  bit          mdir;
  bit          e_inc, e_dec, e_held;

  task automatic model_reset();
    ms1u = 0; ms2u = 0; ms1d = 0; ms2d = 0; mdu = 0; mdd = 0;
    hu = '0; hd = '0;
    mmode = 0; mstart = 0; medge = 0; mdir = 0;
    e_inc = 0; e_dec = 0; e_held = 0;
  endtask

  task automatic model_edge();
    bit pulse, own, oth;
    int age;
    pulse = 0;
    if (rst) begin
      model_reset();
      return;
    end
    e_held = (mmode == 1);
    case (mmode)
      0: begin
        if (mdu && mdd) mmode = 2;
        else if (mdu ^ mdd) begin mmode = 1; mdir = mdu; mstart = medge; end
      end
      2: if (!mdu && !mdd) mmode = 0;
      default: begin
        own = mdir ? mdu : mdd;
        oth = mdir ? mdd : mdu;
        if (oth) mmode = 2;
        else if (!own) mmode = 0;
        else begin
          age = medge - mstart - 1;
          if (age == 0) pulse = 1;
          else if (AR && age >= DLY && ((age - DLY) % RATE) == 0) pulse = 1;
        end
      end
    endcase
    e_inc = pulse &&  mdir && (level_in != 4'hF);
    e_dec = pulse && !mdir && (level_in != 4'h0);
    hu = {hu[DB-2:0], ms2u};
    hd = {hd[DB-2:0], ms2d};
    if (hu == {DB{~mdu}}) mdu = ~mdu;
    if (hd == {DB{~mdd}}) mdd = ~mdd;
    ms2u = ms1u; ms1u = ~btn_up_n;
    ms2d = ms1d; ms1d = ~btn_dn_n;
    medge++;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s t=%0t observed=%b expected=%b", tag, $time, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s t=%0t observed=%0d expected=%0d", tag, $time, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk({phase, "_inc"},  inc,  e_inc);
    chk({phase, "_dec"},  dec,  e_dec);
    chk({phase, "_held"}, held, e_held);
    if (inc) n_inc++;
    if (dec) n_dec++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst = 1'b1; btn_up_n = 1'b1; btn_dn_n = 1'b1; level_in = 4'h8;
    model_reset();
    #2;
    chk("rst_inc", inc, 1'b0);
    chk("rst_dec", dec, 1'b0);
    chk("rst_held", held, 1'b0);
    run(2);
    rst = 1'b0;
    run(5);

    // 1: single press, first pulse latency
    phase = "t1"; n_inc = 0; n_dec = 0;
    btn_up_n = 1'b0;
    run(7);
    chk("t1_no_inc_e6", inc, 1'b0);
    run(1);
    chk("t1_inc_e7", inc, 1'b1);
    chk("t1_held_e7", held, 1'b1);
    run(2);
    btn_up_n = 1'b1;
    run(15);
    chk_int("t1_inc_count", n_inc, 1);
    chk_int("t1_dec_count", n_dec, 0);

    // 2: long down hold with auto-repeat
    phase = "t2"; n_inc = 0; n_dec = 0;
    btn_dn_n = 1'b0;
    run(60);
    btn_dn_n = 1'b1;
    run(20);
    chk_int("t2_dec_count", n_dec, AR ? 6 : 1);
    chk_int("t2_inc_count", n_inc, 0);

    // 3: glitch rejection, then the shortest accepted press
    phase = "t3"; n_inc = 0;
    btn_up_n = 1'b0; run(3); btn_up_n = 1'b1; run(15);
    chk_int("t3_glitch_count", n_inc, 0);
    btn_up_n = 1'b0; run(4); btn_up_n = 1'b1; run(15);
    chk_int("t3_min_press_count", n_inc, 1);

    // 4: upper limit guard, lifted mid-hold
    phase = "t4"; n_inc = 0; level_in = 4'hF;
    btn_up_n = 1'b0;
    run(31);
    chk("t4_held_at_limit", held, 1'b1);
    chk_int("t4_suppressed", n_inc, 0);
    level_in = 4'hE;
    run(9);
    btn_up_n = 1'b1;
    run(20);
    chk_int("t4_inc_count", n_inc, AR ? 2 : 0);
    level_in = 4'h8;

    // 5: opposite key locks out until both released
    phase = "t5"; n_inc = 0; n_dec = 0;
    btn_up_n = 1'b0; run(30);
    btn_dn_n = 1'b0; run(15);
    btn_up_n = 1'b1; run(15);
    chk("t5_locked_held", held, 1'b0);
    chk_int("t5_inc_count", n_inc, AR ? 3 : 1);
    chk_int("t5_dec_locked", n_dec, 0);
    btn_dn_n = 1'b1; run(15);
    n_dec = 0;
    btn_dn_n = 1'b0;
    run(8);
    chk("t5_dec_e7", dec, 1'b1);
    run(2);
    btn_dn_n = 1'b1; run(15);
    chk_int("t5_dec_count", n_dec, 1);

    // 6: reset mid-repeat, key kept held
    phase = "t6";
    btn_up_n = 1'b0;
    run(40);
    rst = 1'b1;
    model_reset();
    #1;
    chk("t6_rst_inc", inc, 1'b0);
    chk("t6_rst_dec", dec, 1'b0);
    chk("t6_rst_held", held, 1'b0);
    tick();
    rst = 1'b0;
    n_inc = 0;
    run(7);
    chk("t6_no_inc_e6", inc, 1'b0);
    run(1);
    chk("t6_inc_e7", inc, 1'b1);
    run(52);
    btn_up_n = 1'b1;
    run(20);
    chk_int("t6_inc_count", n_inc, AR ? 6 : 1);

    // Random key combinations, press lengths and levels
    phase = "rnd";
    for (int i = 0; i < 50; i++) begin
      int r;
      r = int'($urandom_range(0, 5));
      btn_up_n = !(r == 1 || r == 2 || r == 5);
      btn_dn_n = !(r == 3 || r == 4 || r == 5);
      if ($urandom_range(0, 3) == 0) level_in = 4'($urandom_range(0, 15));
      run(int'($urandom_range(1, 30)));
    end
    btn_up_n = 1'b1; btn_dn_n = 1'b1;
    run(30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
